// File: rtl/prog_seq.sv
// prog_seq -- program sequencer that fetches 8-bit words from program memory
// and issues 4-bit instructions to an ICU.
//
// Program word layout: [7:4] opcode, [3:0] operand.
//   4'hC  JMP   the next word holds the full 8-bit jump target
//   4'hF  HALT  stop until 'run' is pulsed, then resume at the following word
//   4'hE  SKZ   skip the next word when 'result' is 0 (PROG_SEQ_SKZ_EN only)
//   other       issued to the ICU as I = opcode, io_addr = operand
//
// Optional feature macro: PROG_SEQ_SKZ_EN
//   Defined   : opcode 4'hE is the skip-if-zero instruction.
//   Undefined : opcode 4'hE is an ordinary ICU opcode, and 'result' is unused.
//
// Ports
//   clk        in   system clock; all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   run        in   resume request, looked at only while halted
//   mem_req    out  program-memory read request
//   mem_addr   out  program-memory word address (always the PC)
//   mem_data   in   program word returned by memory
//   mem_ready  in   memory data valid; a transfer needs mem_req and mem_ready
//   result     in   ICU result register, tested by SKZ
//   I          out  instruction to the ICU (4'h0 when nothing is issued)
//   io_addr    out  operand of the issued instruction (4'h0 when not issuing)
//   issue      out  one-cycle strobe marking a real ICU instruction on I
//   halted     out  high while in the HALT state
module prog_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_data,
  input  logic       mem_ready,
  input  logic       result,
  output logic [3:0] I,
  output logic [3:0] io_addr,
  output logic       issue,
  output logic       halted
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_JTGT  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_SKZ  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [1:0] state_reg, state_next;
  logic [7:0] pc_reg, pc_next;
  logic [7:0] ir_reg, ir_next;

  logic [3:0] opcode;
  logic [7:0] pc_plus1;
  logic       icu_op;
  logic       in_fetch_or_jtgt;
  logic       xfer;

  assign opcode   = ir_reg[7:4];
  assign pc_plus1 = pc_reg + 8'd1;

  // Opcodes that are consumed by the sequencer itself never reach the ICU.
`ifdef PROG_SEQ_SKZ_EN
  assign icu_op = (opcode != OP_JMP) && (opcode != OP_HALT) && (opcode != OP_SKZ);
`else
  assign icu_op = (opcode != OP_JMP) && (opcode != OP_HALT);
  // result only matters to SKZ; keep the port but consume it explicitly.
  logic unused_result;
  assign unused_result = result;
`endif

  assign in_fetch_or_jtgt = (state_reg == S_FETCH) || (state_reg == S_JTGT);

  // A ready pulse counts only while a request is outstanding, so stray
  // mem_ready activity in ISSUE/HALT is ignored.
  assign xfer = in_fetch_or_jtgt && mem_ready;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    case (state_reg)
      S_FETCH: begin
        if (xfer) begin
          ir_next    = mem_data;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Every opcode steps past its own word; JMP then reads the target
        // word at the new PC, SKZ may step one further.
        pc_next    = pc_plus1;
        state_next = S_FETCH;
        if (opcode == OP_JMP) begin
          state_next = S_JTGT;
        end else if (opcode == OP_HALT) begin
          state_next = S_HALT;
        end
`ifdef PROG_SEQ_SKZ_EN
        else if ((opcode == OP_SKZ) && !result) begin
          pc_next = pc_reg + 8'd2;
        end
`endif
      end
      S_JTGT: begin
        if (xfer) begin
          pc_next    = mem_data;
          state_next = S_FETCH;
        end
      end
      S_HALT: begin
        if (run) begin
          state_next = S_FETCH;
        end
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      pc_reg    <= 8'h00;
      ir_reg    <= 8'h00;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  // Outputs decode only state, PC and IR. They are also forced idle while
  // rst is high, so the bus is quiet even in the cycle reset is applied and
  // the registers have not yet been cleared.
  always_comb begin
    mem_req  = !rst && in_fetch_or_jtgt;
    mem_addr = rst ? 8'h00 : pc_reg;
    issue    = !rst && (state_reg == S_ISSUE) && icu_op;
    I        = issue ? ir_reg[7:4] : 4'h0;
    io_addr  = issue ? ir_reg[3:0] : 4'h0;
    halted   = !rst && (state_reg == S_HALT);
  end

endmodule

// File: tb/tb_prog_seq.sv
// tb_prog_seq -- self-checking bench for prog_seq.
// A program-level reference interpreter walks the memory image and produces
// the ordered list of memory reads the sequencer must make; the per-cycle
// checker derives issue/halt/request expectations from each read word.
module tb_prog_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic       result;
  logic [3:0] I;
  logic [3:0] io_addr;
  logic       issue;
  logic       halted;

  prog_seq dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .result    (result),
    .I         (I),
    .io_addr   (io_addr),
    .issue     (issue),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] addr;
    logic       tgt;   // 1: jump-target read, 0: instruction fetch
  } acc_t;

  acc_t       expq[$];
  logic [7:0] mem [0:255];
  int         total = 0;
  int         bad = 0;
  int         mode;        // 0: ready never, 1: ready always, 2: random
  int         halt_hold;   // cycles to stay halted before pulsing run
  int         hold_cnt;
  logic       st_issue, st_after, exp_issue, exp_halted, halt_word;
  logic [3:0] exp_i, exp_io;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_icu(input logic [3:0] op);
`ifdef PROG_SEQ_SKZ_EN
    return (op != 4'hC) && (op != 4'hF) && (op != 4'hE);
`else
    return (op != 4'hC) && (op != 4'hF);
`endif
  endfunction

  // Reference interpreter: program order of memory reads starting at PC 0.
  task automatic build_trace(input int n);
    logic [7:0] pc, nx;
    acc_t e;
    pc = 8'h00;
    expq.delete();
    while (expq.size() < n) begin
      e.addr = pc; e.tgt = 1'b0;
      expq.push_back(e);
      nx = pc + 8'd1;
      if (mem[pc][7:4] == 4'hC) begin
        e.addr = nx; e.tgt = 1'b1;
        expq.push_back(e);
        pc = mem[nx];
      end
`ifdef PROG_SEQ_SKZ_EN
      else if (mem[pc][7:4] == 4'hE) begin
        pc = result ? nx : pc + 8'd2;
      end
`endif
      else begin
        pc = nx;
      end
    end
  endtask

  task automatic clear_flags();
    st_issue = 1'b0; st_after = 1'b0; exp_issue = 1'b0;
    exp_halted = 1'b0; halt_word = 1'b0; hold_cnt = 0;
    exp_i = 4'h0; exp_io = 4'h0;
  endtask

  // One clock of checking plus stimulus, at the falling edge.
  task automatic step();
    acc_t e;
    logic [7:0] w;
    @(negedge clk);
    if (st_after) begin
      if (halt_word) exp_halted = 1'b1;
      else chk("req_after_issue", mem_req, 1);
      halt_word = 1'b0;
    end
    chk("halted", halted, exp_halted);
    if (exp_halted) chk("req_in_halt", mem_req, 0);
    if (st_issue) chk("req_in_issue", mem_req, 0);
    chk("issue", issue, exp_issue);
    chk("I", I, exp_issue ? exp_i : 4'h0);
    chk("io_addr", io_addr, exp_issue ? exp_io : 4'h0);
    st_after = st_issue; st_issue = 1'b0; exp_issue = 1'b0;

    if (exp_halted) begin
      hold_cnt++;
      if (hold_cnt >= halt_hold) begin
        run = 1'b1; exp_halted = 1'b0; hold_cnt = 0;
      end else begin
        run = 1'b0;
      end
    end else begin
      run = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    case (mode)
      0: mem_ready = 1'b0;
      1: mem_ready = 1'b1;
      default: mem_ready = ($urandom_range(0, 2) != 0);
    endcase
    mem_data = mem_req ? mem[mem_addr] : 8'($urandom);

    if (mem_req && mem_ready) begin
      if (expq.size() > 0) e = expq.pop_front();
      else begin e.addr = 8'hxx; e.tgt = 1'b1; end
      chk("xfer_addr", mem_addr, e.addr);
      if (!e.tgt) begin
        w = mem[e.addr];
        st_issue = 1'b1;
        halt_word = (w[7:4] == 4'hF);
        if (is_icu(w[7:4])) begin
          exp_issue = 1'b1; exp_i = w[7:4]; exp_io = w[3:0];
        end
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; run = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 8'h00);
      chk("rst_I", I, 4'h0);
      chk("rst_io", io_addr, 4'h0);
      chk("rst_issue", issue, 0);
      chk("rst_halted", halted, 0);
      mem_ready = 1'($urandom_range(0, 1));
      mem_data = 8'($urandom);
    end
    clear_flags();
    expq.delete();
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_req", mem_req, 1);
    chk("post_rst_addr", mem_addr, 8'h00);
  endtask

  task automatic run_loop(input int budget);
    int c;
    c = 0;
    while (expq.size() > 0 && c < budget) begin
      step();
      c++;
    end
    chk("trace_drained", 8'(expq.size()), 8'h00);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = {4'h1, 4'(i)};
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; mem_data = 8'h00; result = 1'b0;
    mode = 1; halt_hold = 10;
    clear_flags();

    // Directed program: 0x12,0x34 first; JMP at 0x05 -> 0x40; JMP at 0x41
    // -> 0x0A where a HALT waits 10 cycles before resuming at 0x0B.
    fill_mem();
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34;
    mem[8'h05] = 8'hC0; mem[8'h06] = 8'h40;
    mem[8'h41] = 8'hC0; mem[8'h42] = 8'h0A;
    mem[8'h0A] = 8'hF0;
    do_reset(3);
    build_trace(16);
    mode = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wait_req", mem_req, 1);
      chk("wait_addr", mem_addr, 8'h00);
    end
    mode = 1;
    run_loop(200);

    // Reset while stalled in the jump-target read.
    fill_mem();
    mem[8'h00] = 8'hC0; mem[8'h01] = 8'h80;
    do_reset(2);
    build_trace(2);
    mode = 1; step();
    mode = 0; step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("jtgt_req", mem_req, 1);
      chk("jtgt_addr", mem_addr, 8'h01);
    end
    do_reset(1);
    mem[8'h00] = 8'h5A;
    build_trace(6);
    mode = 1;
    run_loop(100);

`ifdef PROG_SEQ_SKZ_EN
    // SKZ at the top of memory: skip wraps to 0x00, no skip reads 0xFF.
    for (int r = 0; r < 2; r++) begin
      fill_mem();
      mem[8'h00] = 8'hC0; mem[8'h01] = 8'hFE;
      mem[8'hFE] = 8'hE5; mem[8'hFF] = 8'h37;
      result = 1'(r);
      do_reset(1);
      build_trace(8);
      mode = 2;
      run_loop(200);
    end
`endif

    // Random programs, random wait states, stray ready and run pulses.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      result = 1'($urandom_range(0, 1));
      halt_hold = $urandom_range(1, 6);
      do_reset(2);
      build_trace(120);
      mode = 2;
      run_loop(3000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_seq.md
PROG_SEQ -- requirements
Module: prog_seq

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: run  input  1  resume request, sampled only in HALT.
REQ-004 SHALL have port: mem_req  output  1  program-memory read request.
REQ-005 SHALL have port: mem_addr  output  8  program-memory word address (= PC during requests).
REQ-006 SHALL have port: mem_data  input  8  program word; [7:4] opcode, [3:0] operand.
REQ-007 SHALL have port: mem_ready  input  1  memory data valid; a transfer occurs on a rising edge where mem_req and mem_ready are both 1.
REQ-008 SHALL have port: result  input  1  ICU result register (RR), used by SKZ.
REQ-009 SHALL have port: I  output  4  instruction to the ICU; 4'h0 (NOP) when not issuing.
REQ-010 SHALL have port: io_addr  output  4  operand of the issued instruction; 4'h0 when not issuing.
REQ-011 SHALL have port: issue  output  1  high for exactly the one cycle in which I carries a real ICU instruction.
REQ-012 SHALL have port: halted  output  1  high while in HALT.

Function
REQ-013 SHALL implement the states FETCH, ISSUE, JTGT, HALT with an 8-bit PC and an 8-bit instruction register (IR).
REQ-014 FETCH: mem_req=1, mem_addr=PC; SHALL stay until transfer, then load IR<=mem_data, go to ISSUE; wait states unbounded.
REQ-015 ISSUE, ordinary opcode (not 4'hC/4'hE/4'hF): I=IR[7:4], io_addr=IR[3:0], issue=1 for one cycle; PC<=PC+1; next FETCH.
REQ-016 Opcode 4'hC (JMP) in ISSUE: I=4'h0, issue=0, PC<=PC+1, next JTGT.
REQ-017 JTGT: mem_req=1, mem_addr=PC; on transfer PC<=mem_data (full 8-bit target), next FETCH.
REQ-018 Opcode 4'hF (HALT) in ISSUE: I=4'h0, issue=0, PC<=PC+1, next HALT.
REQ-019 HALT: mem_req=0, halted=1; run=1 -> FETCH next cycle at current PC; run=0 -> stay.
REQ-020 mem_req SHALL be 0 in ISSUE and HALT; mem_addr SHALL be held at PC in all states.
REQ-021 PC arithmetic SHALL be modulo 256: 8'hFF+1 -> 8'h00, 8'hFF+2 -> 8'h01.
REQ-022 Minimum throughput SHALL be one ICU instruction per 2 cycles with zero-wait memory; JMP costs 3 cycles minimum.
REQ-023 All outputs SHALL be registered or decoded from state/IR only; no combinational path from mem_data, mem_ready or result to any output.
REQ-024 A mem_ready pulse while mem_req=0 SHALL be ignored.

Reset
REQ-025 rst=1 at a rising edge SHALL, from any state (including mid-wait in FETCH/JTGT), set PC=8'h00, IR=8'h00, state=FETCH.
REQ-026 While rst=1: mem_req=0, mem_addr=8'h00, I=4'h0, io_addr=4'h0, issue=0, halted=0.
REQ-027 First cycle after rst falls SHALL be FETCH with mem_req=1, mem_addr=8'h00.

Configuration
REQ-028 Macro PROG_SEQ_SKZ_EN SHALL gate the skip-if-zero feature.
REQ-029 Defined: opcode 4'hE (SKZ) in ISSUE drives I=4'h0, issue=0; PC<=PC+2 if result==0 (sampled that cycle), else PC<=PC+1; next FETCH. A skipped JMP's target word is not skipped (it executes as an instruction).
REQ-030 Undefined: opcode 4'hE SHALL be treated as an ordinary opcode per REQ-015; result port SHALL remain present and unused.

Verification
REQ-031 Reset release, zero-wait memory, words 0x12,0x34 at 0,1 -> issue pulses with I=1/io_addr=2 then I=3/io_addr=4, 2 cycles apart; mem_addr 0,1,2.
REQ-032 mem_ready held low 5 cycles in FETCH -> mem_req stays 1, mem_addr stable, issue=0 throughout; instruction issued the cycle after ready.
REQ-033 Word 0xC0 at 0x05, 0x40 at 0x06 -> no issue for JMP, next fetch at mem_addr=0x40.
REQ-034 HALT word 0xF0 at 0x0A -> halted=1, mem_req=0 for 10 cycles; run=1 one cycle -> fetch resumes at 0x0B.
REQ-035 With PROG_SEQ_SKZ_EN: SKZ at 0xFE, result=0 -> next fetch at 0x00 (wrap); result=1 -> next fetch at 0xFF.
REQ-036 rst asserted during JTGT wait -> next cycle outputs per REQ-026; after release fetch at 0x00.
